// File: rtl/wb_aperture_pkg.sv
// Shared definitions for the Wishbone aperture controller.
//   state_e      : controller FSM encoding (idle / waiting for ACK / one-cycle ACK guard)
//   SLV_*        : slave index into Slv_CYC_o, Slv_ACK_i and Slv_RD_DAT_i
package wb_aperture_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam int unsigned SLV_FPGA_REG = 0;
    localparam int unsigned SLV_UART0    = 1;
    localparam int unsigned SLV_QL_RES   = 2;
    localparam int unsigned NUM_SLV      = 3;

endpackage

// File: rtl/wb_ack_timeout.sv
// Timeout counter and timeout log for wb_aperture_ctrl.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : first cycle of an access that was not acknowledged at once (cnt <= 1)
//   run_i          : access still waiting (cnt <= cnt + 1); with neither strobe cnt <= 0
//   tmo_i          : timeout ACK is being issued this cycle; logs adr_i / we_i
//   clr_i          : clears the timeout count, overriding a same-cycle increment
//   cnt_hit_o      : counter has reached the timeout value
//   tmo_event_o    : one-cycle pulse the cycle after a timeout ACK
//   tmo_addr_o/we_o: address and write flag of the last timed-out access
//   tmo_cnt_o      : saturating timeout count
module wb_ack_timeout #(
    parameter int unsigned CntrWidth   = 3,
    parameter int unsigned CntrTimeout = 7,
    parameter int unsigned AdrWidth    = 17
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                run_i,
    input  logic                tmo_i,
    input  logic                clr_i,
    input  logic [AdrWidth-1:0] adr_i,
    input  logic                we_i,
    output logic                cnt_hit_o,
    output logic                tmo_event_o,
    output logic [AdrWidth-1:0] tmo_addr_o,
    output logic                tmo_we_o,
    output logic [7:0]          tmo_cnt_o
);

    if ((CntrTimeout == 0) || (CntrTimeout >= (32'd1 << CntrWidth))) begin : g_bad_timeout
        $error("DEFAULT_CNTR_TIMEOUT must be in 1..2^DEFAULT_CNTR_WIDTH-1");
    end

    localparam logic [CntrWidth-1:0] TmoVal = CntrWidth'(CntrTimeout);

    logic [CntrWidth-1:0] cnt_q, cnt_d;
    logic                 tmo_event_q;
    logic [AdrWidth-1:0]  tmo_addr_q, tmo_addr_d;
    logic                 tmo_we_q, tmo_we_d;
    logic [7:0]           tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        cnt_d = '0;
        if (start_i) begin
            cnt_d = CntrWidth'(1);
        end else if (run_i) begin
            cnt_d = cnt_q + CntrWidth'(1);
        end

        tmo_addr_d = tmo_i ? adr_i : tmo_addr_q;
        tmo_we_d   = tmo_i ? we_i  : tmo_we_q;

        tmo_cnt_d = tmo_cnt_q;
        if (clr_i) begin
            tmo_cnt_d = '0;
        end else if (tmo_i && (tmo_cnt_q != 8'hFF)) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            tmo_event_q <= 1'b0;
            tmo_addr_q  <= '0;
            tmo_we_q    <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            tmo_event_q <= tmo_i;
            tmo_addr_q  <= tmo_addr_d;
            tmo_we_q    <= tmo_we_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign cnt_hit_o   = (cnt_q == TmoVal);
    assign tmo_event_o = tmo_event_q;
    assign tmo_addr_o  = tmo_addr_q;
    assign tmo_we_o    = tmo_we_q;
    assign tmo_cnt_o   = tmo_cnt_q;

endmodule

// File: rtl/wb_aperture_ctrl.sv
// Wishbone slave-side controller: decodes the bridge address into three apertures
// (FPGA regs, UART0, QL reserved), steers CYC to the selected slave, muxes ACK and
// read data back, and ends unanswered or unmapped accesses with a timeout ACK.
//   WB_CLK, WB_RST        : clock, synchronous active-high reset
//   WBs_*                 : bridge side (address, cycle, strobe, write flag, ACK, read data)
//   Slv_CYC_o/ACK_i/RD_DAT_i : per-slave cycle, ACK and read data (slave i at bit/word i)
//   Tmo_*                 : timeout log (event pulse, address, write flag, count, count clear)
module wb_aperture_ctrl
    import wb_aperture_pkg::*;
#(
    parameter int unsigned           APERWIDTH                = 17,
    parameter int unsigned           APERSIZE                 = 10,
    parameter logic [APERWIDTH-1:0]  FPGA_REG_BASE_ADDRESS    = 17'h00000,
    parameter logic [APERWIDTH-1:0]  UART0_BASE_ADDRESS       = 17'h01000,
    parameter logic [APERWIDTH-1:0]  QL_RESERVED_BASE_ADDRESS = 17'h03000,
    parameter logic [31:0]           DEFAULT_READ_VALUE       = 32'hBAD_FAB_AC,
    parameter int unsigned           DEFAULT_CNTR_WIDTH       = 3,
    parameter int unsigned           DEFAULT_CNTR_TIMEOUT     = 7
) (
    input  logic                   WB_CLK,
    input  logic                   WB_RST,
    input  logic [APERWIDTH-1:0]   WBs_ADR,
    input  logic                   WBs_CYC,
    input  logic                   WBs_STB,
    input  logic                   WBs_WE,
    output logic                   WBs_ACK,
    output logic [31:0]            WBs_RD_DAT,
    output logic [NUM_SLV-1:0]     Slv_CYC_o,
    input  logic [NUM_SLV-1:0]     Slv_ACK_i,
    input  logic [32*NUM_SLV-1:0]  Slv_RD_DAT_i,
    output logic                   Tmo_Event_o,
    output logic [APERWIDTH-1:0]   Tmo_Addr_o,
    output logic                   Tmo_WE_o,
    output logic [7:0]             Tmo_Cnt_o,
    input  logic                   Tmo_Clr_i
);

    localparam int unsigned DecLsb = APERSIZE + 2;

    localparam logic [APERWIDTH-1:DecLsb] BaseFpga = FPGA_REG_BASE_ADDRESS[APERWIDTH-1:DecLsb];
    localparam logic [APERWIDTH-1:DecLsb] BaseUart = UART0_BASE_ADDRESS[APERWIDTH-1:DecLsb];
    localparam logic [APERWIDTH-1:DecLsb] BaseQl   = QL_RESERVED_BASE_ADDRESS[APERWIDTH-1:DecLsb];

    if ((BaseFpga == BaseUart) || (BaseFpga == BaseQl) || (BaseUart == BaseQl)) begin : g_bad_bases
        $error("aperture base addresses must decode to distinct apertures");
    end

    state_e             state_q, state_d;
    logic [NUM_SLV-1:0] hit;
    logic [31:0]        hit_dat;
    logic               sel_ack, tmo_ack, cnt_hit, cnt_start, cnt_run;

    // Apertures are distinct, so at most one hit bit is set.
    always_comb begin
        hit = '0;
        hit[SLV_FPGA_REG] = (WBs_ADR[APERWIDTH-1:DecLsb] == BaseFpga);
        hit[SLV_UART0]    = (WBs_ADR[APERWIDTH-1:DecLsb] == BaseUart);
        hit[SLV_QL_RES]   = (WBs_ADR[APERWIDTH-1:DecLsb] == BaseQl);

        hit_dat = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (hit[i]) begin
                hit_dat = Slv_RD_DAT_i[32*i +: 32];
            end
        end
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (WBs_CYC && WBs_STB) begin
                    state_d = sel_ack ? StDone : StActive;
                end
            end
            StActive: begin
                if (!WBs_CYC) begin
                    state_d = StIdle;
                end else if (sel_ack || tmo_ack) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reset and the DONE guard cycle both silence every ACK and slave CYC.
    always_comb begin
        sel_ack = (|(Slv_ACK_i & hit)) && WBs_CYC && WBs_STB && (state_q != StDone) && !WB_RST;
        // A bridge abort (CYC low) takes priority over the timeout.
        tmo_ack = (state_q == StActive) && WBs_CYC && cnt_hit && !sel_ack && !WB_RST;

        Slv_CYC_o  = (WBs_CYC && (state_q != StDone) && !WB_RST) ? hit : '0;
        WBs_ACK    = sel_ack || tmo_ack;
        WBs_RD_DAT = sel_ack ? hit_dat : DEFAULT_READ_VALUE;

        cnt_start = (state_q == StIdle) && WBs_CYC && WBs_STB && !sel_ack;
        cnt_run   = (state_q == StActive) && WBs_CYC && !sel_ack && !tmo_ack;
    end

    wb_ack_timeout #(
        .CntrWidth   (DEFAULT_CNTR_WIDTH),
        .CntrTimeout (DEFAULT_CNTR_TIMEOUT),
        .AdrWidth    (APERWIDTH)
    ) u_ack_timeout (
        .clk_i       (WB_CLK),
        .rst_i       (WB_RST),
        .start_i     (cnt_start),
        .run_i       (cnt_run),
        .tmo_i       (tmo_ack),
        .clr_i       (Tmo_Clr_i),
        .adr_i       (WBs_ADR),
        .we_i        (WBs_WE),
        .cnt_hit_o   (cnt_hit),
        .tmo_event_o (Tmo_Event_o),
        .tmo_addr_o  (Tmo_Addr_o),
        .tmo_we_o    (Tmo_WE_o),
        .tmo_cnt_o   (Tmo_Cnt_o)
    );

endmodule

// File: tb/tb_wb_aperture_ctrl.sv
// Directed bench for wb_aperture_ctrl. Inputs change 1 ns after the rising edge; outputs
// are sampled on the falling edge. Cycle 0 of an access is the first CYC&STB cycle.
module tb_wb_aperture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] adr;
    logic        cyc, stb, we;
    logic        ack;
    logic [31:0] rd_dat;
    logic [2:0]  slv_cyc;
    logic [2:0]  slv_ack;
    logic [95:0] slv_dat;
    logic        tmo_event;
    logic [16:0] tmo_addr;
    logic        tmo_we;
    logic [7:0]  tmo_cnt;
    logic        tmo_clr;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] DefVal = 32'hBADFABAC;

    assign slv_dat = {32'h2222_2222, 32'h1111_1111, 32'h0000_0001};

    always #5 clk = ~clk;

    wb_aperture_ctrl dut (
        .WB_CLK       (clk),
        .WB_RST       (rst),
        .WBs_ADR      (adr),
        .WBs_CYC      (cyc),
        .WBs_STB      (stb),
        .WBs_WE       (we),
        .WBs_ACK      (ack),
        .WBs_RD_DAT   (rd_dat),
        .Slv_CYC_o    (slv_cyc),
        .Slv_ACK_i    (slv_ack),
        .Slv_RD_DAT_i (slv_dat),
        .Tmo_Event_o  (tmo_event),
        .Tmo_Addr_o   (tmo_addr),
        .Tmo_WE_o     (tmo_we),
        .Tmo_Cnt_o    (tmo_cnt),
        .Tmo_Clr_i    (tmo_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access. The bridge holds CYC/STB for one cycle after the first ACK (the slave
    // keeps its ACK up too), then drops them. Records ACK timing/data and the event cycle.
    task automatic do_access(input logic [16:0] a, input logic w, input int ack_at,
                             input logic [2:0] ack_mask, output int ack_cycle,
                             output logic [31:0] dat, output int ack_count,
                             output logic [2:0] cyc_seen, output int evt_cycle);
        logic active;
        ack_cycle = -1; dat = '0; ack_count = 0; cyc_seen = '0; evt_cycle = -1;
        for (int k = 0; k < 14; k++) begin
            step();
            active  = (ack_cycle < 0) || (k <= ack_cycle + 1);
            cyc     = active;
            stb     = active;
            adr     = a;
            we      = w;
            slv_ack = (active && ack_at >= 0 && k >= ack_at) ? ack_mask : 3'b000;
            @(negedge clk);
            cyc_seen |= slv_cyc;
            if (ack) begin
                ack_count++;
                if (ack_cycle < 0) begin
                    ack_cycle = k;
                    dat = rd_dat;
                end
            end
            if (tmo_event && evt_cycle < 0) evt_cycle = k;
            if (ack_cycle >= 0 && k == ack_cycle + 2) break;
        end
        step();
        cyc = 1'b0; stb = 1'b0; slv_ack = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; adr = 17'h00004; we = 1'b0;
        slv_ack = 3'b001; tmo_clr = 1'b0;
        step(); step();
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (slv_cyc !== 3'b000) begin errors++; $display("FAIL reset_slv_cyc: got %b want 000", slv_cyc); end
        checks++; if (tmo_event !== 1'b0) begin errors++; $display("FAIL reset_event: got %b want 0", tmo_event); end
        checks++; if (tmo_addr !== 17'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", tmo_addr); end
        checks++; if (tmo_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", tmo_we); end
        checks++; if (tmo_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h want 00", tmo_cnt); end
        step();
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; slv_ack = '0;
        step();
    endtask

    task automatic test_fpga_read();
        int ac, cnt, ev; logic [31:0] d; logic [2:0] cs;
        do_access(17'h00004, 1'b0, 2, 3'b001, ac, d, cnt, cs, ev);
        checks++; if (cs !== 3'b001) begin errors++; $display("FAIL fpga_slv_cyc: got %b want 001", cs); end
        checks++; if (ac !== 2) begin errors++; $display("FAIL fpga_ack_cycle: got %0d want 2", ac); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL fpga_ack_count: got %0d want 1", cnt); end
        checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL fpga_data: got %h want 00000001", d); end
        checks++; if (ev !== -1) begin errors++; $display("FAIL fpga_event: got cycle %0d want none", ev); end
        checks++; if (tmo_cnt !== 8'd0) begin errors++; $display("FAIL fpga_tmo_cnt: got %0d want 0", tmo_cnt); end
    endtask

    task automatic test_uart_timeout();
        int ac, cnt, ev; logic [31:0] d; logic [2:0] cs;
        do_access(17'h01008, 1'b1, -1, 3'b000, ac, d, cnt, cs, ev);
        checks++; if (cs !== 3'b010) begin errors++; $display("FAIL uart_slv_cyc: got %b want 010", cs); end
        checks++; if (ac !== 7) begin errors++; $display("FAIL uart_ack_cycle: got %0d want 7", ac); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL uart_ack_count: got %0d want 1", cnt); end
        checks++; if (d !== DefVal) begin errors++; $display("FAIL uart_data: got %h want %h", d, DefVal); end
        checks++; if (ev !== 8) begin errors++; $display("FAIL uart_event: got cycle %0d want 8", ev); end
        checks++; if (tmo_addr !== 17'h01008) begin errors++; $display("FAIL uart_tmo_addr: got %h want 01008", tmo_addr); end
        checks++; if (tmo_we !== 1'b1) begin errors++; $display("FAIL uart_tmo_we: got %b want 1", tmo_we); end
        checks++; if (tmo_cnt !== 8'd1) begin errors++; $display("FAIL uart_tmo_cnt: got %0d want 1", tmo_cnt); end
    endtask

    task automatic test_unmapped();
        int ac, cnt, ev; logic [31:0] d; logic [2:0] cs;
        do_access(17'h02000, 1'b0, 1, 3'b111, ac, d, cnt, cs, ev);
        checks++; if (cs !== 3'b000) begin errors++; $display("FAIL unmap_slv_cyc: got %b want 000", cs); end
        checks++; if (ac !== 7) begin errors++; $display("FAIL unmap_ack_cycle: got %0d want 7", ac); end
        checks++; if (d !== DefVal) begin errors++; $display("FAIL unmap_data: got %h want %h", d, DefVal); end
        checks++; if (tmo_addr !== 17'h02000) begin errors++; $display("FAIL unmap_tmo_addr: got %h want 02000", tmo_addr); end
        checks++; if (tmo_we !== 1'b0) begin errors++; $display("FAIL unmap_tmo_we: got %b want 0", tmo_we); end
        checks++; if (tmo_cnt !== 8'd2) begin errors++; $display("FAIL unmap_tmo_cnt: got %0d want 2", tmo_cnt); end
    endtask

    task automatic test_collision();
        int ac, cnt, ev; logic [31:0] d; logic [2:0] cs;
        do_access(17'h03010, 1'b0, 7, 3'b100, ac, d, cnt, cs, ev);
        checks++; if (cs !== 3'b100) begin errors++; $display("FAIL coll_slv_cyc: got %b want 100", cs); end
        checks++; if (ac !== 7) begin errors++; $display("FAIL coll_ack_cycle: got %0d want 7", ac); end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL coll_ack_count: got %0d want 1", cnt); end
        checks++; if (d !== 32'h2222_2222) begin errors++; $display("FAIL coll_data: got %h want 22222222", d); end
        checks++; if (ev !== -1) begin errors++; $display("FAIL coll_event: got cycle %0d want none", ev); end
        checks++; if (tmo_cnt !== 8'd2) begin errors++; $display("FAIL coll_tmo_cnt: got %0d want 2", tmo_cnt); end
    endtask

    task automatic test_wrong_slave_ack();
        int ac, cnt, ev; logic [31:0] d; logic [2:0] cs;
        do_access(17'h01000, 1'b0, 2, 3'b001, ac, d, cnt, cs, ev);
        checks++; if (ac !== 7) begin errors++; $display("FAIL wrong_ack_cycle: got %0d want 7", ac); end
        checks++; if (d !== DefVal) begin errors++; $display("FAIL wrong_data: got %h want %h", d, DefVal); end
        checks++; if (tmo_cnt !== 8'd3) begin errors++; $display("FAIL wrong_tmo_cnt: got %0d want 3", tmo_cnt); end
    endtask

    task automatic test_abort();
        int acks = 0; int evs = 0;
        int ac, cnt, ev; logic [31:0] d; logic [2:0] cs;
        for (int k = 0; k < 12; k++) begin
            step();
            cyc = (k < 3); stb = (k < 3); adr = 17'h00010; we = 1'b0; slv_ack = '0;
            @(negedge clk);
            if (ack) acks++;
            if (tmo_event) evs++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
        checks++; if (evs !== 0) begin errors++; $display("FAIL abort_event: got %0d events want 0", evs); end
        checks++; if (tmo_cnt !== 8'd3) begin errors++; $display("FAIL abort_tmo_cnt: got %0d want 3", tmo_cnt); end
        // A fresh access must see an idle FSM and a counter starting from zero.
        do_access(17'h02004, 1'b0, -1, 3'b000, ac, d, cnt, cs, ev);
        checks++; if (ac !== 7) begin errors++; $display("FAIL abort_next_ack: got %0d want 7", ac); end
        checks++; if (tmo_cnt !== 8'd4) begin errors++; $display("FAIL abort_next_cnt: got %0d want 4", tmo_cnt); end
    endtask

    task automatic test_reset_mid();
        int ac, cnt, ev; logic [31:0] d; logic [2:0] cs;
        for (int k = 0; k < 6; k++) begin
            step();
            rst = (k == 4); cyc = (k < 5); stb = (k < 5); adr = 17'h01004; we = 1'b1; slv_ack = '0;
            @(negedge clk);
            if (k == 4) begin
                checks++; if (slv_cyc !== 3'b000) begin errors++; $display("FAIL rstmid_slv_cyc: got %b want 000", slv_cyc); end
                checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", ack); end
            end
            if (k == 5) begin
                checks++; if (tmo_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", tmo_cnt); end
                checks++; if (tmo_addr !== 17'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 0", tmo_addr); end
                checks++; if (tmo_event !== 1'b0) begin errors++; $display("FAIL rstmid_event: got %b want 0", tmo_event); end
            end
        end
        do_access(17'h03000, 1'b0, -1, 3'b000, ac, d, cnt, cs, ev);
        checks++; if (ac !== 7) begin errors++; $display("FAIL rstmid_next_ack: got %0d want 7", ac); end
        checks++; if (tmo_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_next_cnt: got %0d want 1", tmo_cnt); end
    endtask

    task automatic test_saturation();
        int ac, cnt, ev; logic [31:0] d; logic [2:0] cs;
        for (int n = 0; n < 260; n++) begin
            do_access(17'h02010, 1'b0, -1, 3'b000, ac, d, cnt, cs, ev);
            if (n == 253) begin
                checks++; if (tmo_cnt !== 8'hFF) begin errors++; $display("FAIL sat_reach: got %h want ff", tmo_cnt); end
            end
        end
        checks++; if (tmo_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h want ff", tmo_cnt); end
    endtask

    task automatic test_clear_collision();
        for (int k = 0; k < 10; k++) begin
            step();
            cyc = (k <= 8); stb = (k <= 8); adr = 17'h02008; we = 1'b1; slv_ack = '0;
            tmo_clr = (k == 7);
            @(negedge clk);
            if (k == 7) begin
                checks++; if (ack !== 1'b1) begin errors++; $display("FAIL clr_ack: got %b want 1", ack); end
            end
            if (k == 8) begin
                checks++; if (tmo_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt: got %h want 00", tmo_cnt); end
                checks++; if (tmo_event !== 1'b1) begin errors++; $display("FAIL clr_event: got %b want 1", tmo_event); end
            end
        end
        tmo_clr = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fpga_read();
        test_uart_timeout();
        test_unmapped();
        test_collision();
        test_wrong_slave_ack();
        test_abort();
        test_reset_mid();
        test_saturation();
        test_clear_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
